f_fetch: RTL and testbench

F_FETCH -- requirements
Module: f_fetch

---
 rtl/f_fetch.sv | 122 ++++++++++++
 tb/tb_f_fetch.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/f_fetch.sv
// Instruction fetch stage: issues one instruction-memory read at a time and
// presents the returned word as a fetch packet, with delay-slot redirects and flushes.
module f_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        F_STALL,
  input  logic        F_flush,
  input  logic [31:0] F_flush_pc,
  input  logic        D_redirect,
  input  logic [31:0] D_target,
  output logic        i_req,
  output logic [31:0] i_addr,
  input  logic        i_rvalid,
  input  logic [31:0] i_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_inStr,
  output logic        F_valid,
  output logic        F_miss,
  output logic        F_excAdEL
);

  typedef enum logic [1:0] {REQ, WAIT, VALID, DROP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ibuf_reg, ibuf_next;
  logic        exc_reg, exc_next;
  logic        redir_pend_reg, redir_pend_next;
  logic [31:0] redir_tgt_reg, redir_tgt_next;
  logic        advance;
  logic        unused_exc_pc;

  // EXC_PC is reserved for whoever drives the flush; it has no effect here.
  assign unused_exc_pc = ^EXC_PC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= REQ;
      pc_reg         <= RESET_PC;
      ibuf_reg       <= '0;
      exc_reg        <= 1'b0;
      redir_pend_reg <= 1'b0;
      redir_tgt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      ibuf_reg       <= ibuf_next;
      exc_reg        <= exc_next;
      redir_pend_reg <= redir_pend_next;
      redir_tgt_reg  <= redir_tgt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    ibuf_next       = ibuf_reg;
    exc_next        = exc_reg;
    redir_pend_next = redir_pend_reg;
    redir_tgt_next  = redir_tgt_reg;
    advance         = (state_reg == VALID) && !F_STALL;

    case (state_reg)
      REQ: begin
        if (pc_reg[1:0] == 2'b00) begin
          state_next = WAIT;
        end else begin
          ibuf_next  = '0;
          exc_next   = 1'b1;
          state_next = VALID;
        end
      end
      WAIT: begin
        if (i_rvalid) begin
          ibuf_next  = i_rdata;
          exc_next   = 1'b0;
          state_next = VALID;
        end
      end
      VALID: begin
        if (advance) begin
          if (D_redirect)          pc_next = D_target;
          else if (redir_pend_reg) pc_next = redir_tgt_reg;
          else                     pc_next = pc_reg + 32'd4;
          redir_pend_next = 1'b0;
          state_next      = REQ;
        end
      end
      DROP: begin
        if (i_rvalid) state_next = REQ;
      end
      default: state_next = REQ;
    endcase

    // A redirect seen while the packet is not consumed applies to the next advance.
    if (D_redirect && !advance) begin
      redir_pend_next = 1'b1;
      redir_tgt_next  = D_target;
    end

    // Flush wins; an in-flight read must still be drained so its data is not mistaken for the new target.
    // A response arriving in the same cycle as a flush in DROP completes the drain.
    if (F_flush) begin
      pc_next         = F_flush_pc;
      redir_pend_next = 1'b0;
      if ((state_reg == WAIT || state_reg == DROP) && !i_rvalid) state_next = DROP;
      else                                                       state_next = REQ;
    end
  end

  assign i_req     = reset && (state_reg == REQ) && (pc_reg[1:0] == 2'b00);
  assign i_addr    = pc_reg;
  assign F_PC      = pc_reg;
  assign F_valid   = (state_reg == VALID);
  assign F_miss    = (state_reg != VALID);
  assign F_inStr   = (state_reg == VALID) ? ibuf_reg : 32'h0;
  assign F_excAdEL = (state_reg == VALID) ? exc_reg : 1'b0;

endmodule

// File: tb/tb_f_fetch.sv
// Directed cycle-by-cycle bench for f_fetch: the bench plays instruction memory
// through the vector table and checks every output of each cycle.
module tb_f_fetch;

  logic        clk;
  logic        reset;
  logic        F_STALL, F_flush, D_redirect, i_rvalid;
  logic [31:0] F_flush_pc, D_target, i_rdata;
  logic        i_req, F_valid, F_miss, F_excAdEL;
  logic [31:0] i_addr, F_PC, F_inStr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall, flush;
    logic [31:0] fpc;
    logic        redir;
    logic [31:0] tgt;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_pc, e_instr;
    logic        e_valid, e_exc;
  } vec_t;

  vec_t tbl[$];

  f_fetch dut (
    .clk(clk), .reset(reset), .F_STALL(F_STALL), .F_flush(F_flush),
    .F_flush_pc(F_flush_pc), .D_redirect(D_redirect), .D_target(D_target),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .F_PC(F_PC), .F_inStr(F_inStr), .F_valid(F_valid), .F_miss(F_miss),
    .F_excAdEL(F_excAdEL)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic stall, input logic flush, input logic [31:0] fpc,
                              input logic redir, input logic [31:0] tgt, input logic rv,
                              input logic [31:0] rd, input logic e_req, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic e_valid, input logic e_exc);
    vec_t v;
    v.stall = stall; v.flush = flush; v.fpc = fpc; v.redir = redir; v.tgt = tgt;
    v.rv = rv; v.rd = rd; v.e_req = e_req; v.e_pc = e_pc; v.e_instr = e_instr;
    v.e_valid = e_valid; v.e_exc = e_exc;
    return v;
  endfunction

  // i_addr always tracks the PC register and F_miss is the complement of F_valid.
  task automatic check_out(input string name, input logic e_req, input logic [31:0] e_pc,
                           input logic [31:0] e_instr, input logic e_valid, input logic e_exc);
    checks++;
    if (i_req !== e_req || i_addr !== e_pc || F_PC !== e_pc || F_inStr !== e_instr ||
        F_valid !== e_valid || F_miss !== !e_valid || F_excAdEL !== e_exc) begin
      errors++;
      $display("FAIL %s: got req=%b addr=%h pc=%h instr=%h valid=%b miss=%b exc=%b, want req=%b addr=%h pc=%h instr=%h valid=%b miss=%b exc=%b",
               name, i_req, i_addr, F_PC, F_inStr, F_valid, F_miss, F_excAdEL,
               e_req, e_pc, e_pc, e_instr, e_valid, !e_valid, e_exc);
    end else begin
      $display("ok   %s: req=%b pc=%h instr=%h valid=%b exc=%b", name, i_req, F_PC, F_inStr, F_valid, F_excAdEL);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    F_STALL = v.stall; F_flush = v.flush; F_flush_pc = v.fpc;
    D_redirect = v.redir; D_target = v.tgt; i_rvalid = v.rv; i_rdata = v.rd;
    #1;
    check_out(name, v.e_req, v.e_pc, v.e_instr, v.e_valid, v.e_exc);
  endtask

  initial begin
    reset = 1'b0;
    F_STALL = 0; F_flush = 0; F_flush_pc = '0; D_redirect = 0; D_target = '0;
    i_rvalid = 0; i_rdata = '0;

    //        stall flush fpc          redir tgt        rv rdata         req pc           instr         vld exc
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     0,32'h0,        1,32'h0000_3000,32'h0,        0,0)); // 0 REQ
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     1,32'h2402000A, 0,32'h0000_3000,32'h0,        0,0)); // 1 WAIT
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,     0,32'h0,        0,32'h0000_3000,32'h2402000A, 1,0)); // 2 stall
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,     1,32'hFFFFFFFF, 0,32'h0000_3000,32'h2402000A, 1,0)); // 3 stall, stray rvalid
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,     0,32'h0,        0,32'h0000_3000,32'h2402000A, 1,0)); // 4 stall
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,     0,32'h0,        0,32'h0000_3000,32'h2402000A, 1,0)); // 5 stall
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     0,32'h0,        0,32'h0000_3000,32'h2402000A, 1,0)); // 6 advance
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     0,32'h0,        1,32'h0000_3004,32'h0,        0,0)); // 7 REQ
    tbl.push_back(mk(0,0,32'h0,        1,32'h3100,  0,32'h0,        0,32'h0000_3004,32'h0,        0,0)); // 8 WAIT + redirect
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     1,32'h8C010004, 0,32'h0000_3004,32'h0,        0,0)); // 9 WAIT
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     0,32'h0,        0,32'h0000_3004,32'h8C010004, 1,0)); // 10 delay slot
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     0,32'h0,        1,32'h0000_3100,32'h0,        0,0)); // 11 REQ target
    tbl.push_back(mk(0,1,32'h4180,     0,32'h0,     0,32'h0,        0,32'h0000_3100,32'h0,        0,0)); // 12 flush in WAIT
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     0,32'h0,        0,32'h0000_4180,32'h0,        0,0)); // 13 DROP
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     1,32'hDEADBEEF, 0,32'h0000_4180,32'h0,        0,0)); // 14 DROP drain
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     0,32'h0,        1,32'h0000_4180,32'h0,        0,0)); // 15 REQ
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     1,32'h3C1D0000, 0,32'h0000_4180,32'h0,        0,0)); // 16 WAIT
    tbl.push_back(mk(0,1,32'h3002,     0,32'h0,     0,32'h0,        0,32'h0000_4180,32'h3C1D0000, 1,0)); // 17 flush misaligned
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     0,32'h0,        0,32'h0000_3002,32'h0,        0,0)); // 18 REQ no req
    tbl.push_back(mk(1,0,32'h0,        1,32'h3200,  0,32'h0,        0,32'h0000_3002,32'h0,        1,1)); // 19 AdEL, pend
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     0,32'h0,        0,32'h0000_3002,32'h0,        1,1)); // 20 advance pend
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     0,32'h0,        1,32'h0000_3200,32'h0,        0,0)); // 21 REQ
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     1,32'h11112222, 0,32'h0000_3200,32'h0,        0,0)); // 22 WAIT
    tbl.push_back(mk(0,0,32'h0,        1,32'h3300,  0,32'h0,        0,32'h0000_3200,32'h11112222, 1,0)); // 23 advance+redirect
    tbl.push_back(mk(0,1,32'h3400,     0,32'h0,     0,32'h0,        1,32'h0000_3300,32'h0,        0,0)); // 24 flush in REQ
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     1,32'hBAD0BAD0, 1,32'h0000_3400,32'h0,        0,0)); // 25 REQ stale rvalid
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,     1,32'h55556666, 0,32'h0000_3400,32'h0,        0,0)); // 26 WAIT
    tbl.push_back(mk(0,1,32'hFFFFFFFC, 0,32'h0,     0,32'h0,        0,32'h0000_3400,32'h55556666, 1,0)); // 27 flush to top
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     0,32'h0,        1,32'hFFFFFFFC,32'h0,        0,0)); // 28 REQ
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     1,32'h0A0B0C0D, 0,32'hFFFFFFFC,32'h0,        0,0)); // 29 WAIT
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     0,32'h0,        0,32'hFFFFFFFC,32'h0A0B0C0D, 1,0)); // 30 advance wraps
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     0,32'h0,        1,32'h0000_0000,32'h0,        0,0)); // 31 REQ at 0
    tbl.push_back(mk(0,0,32'h0,        0,32'h0,     0,32'h0,        0,32'h0000_0000,32'h0,        0,0)); // 32 WAIT

    repeat (2) @(posedge clk);
    #1;
    check_out("in_reset", 1'b0, 32'h0000_3000, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Flush in WAIT with data arriving the same cycle goes straight to REQ.
    run_vec(mk(0,1,32'h3008, 0,32'h0, 1,32'h77777777, 0,32'h0000_0000,32'h0, 0,0), "flush_wait_rv");
    run_vec(mk(0,0,32'h0,    0,32'h0, 0,32'h0,        1,32'h0000_3008,32'h0, 0,0), "req_3008");
    run_vec(mk(0,0,32'h0,    0,32'h0, 0,32'h0,        0,32'h0000_3008,32'h0, 0,0), "wait_3008");

    // Asynchronous reset in the middle of the WAIT cycle, between clock edges.
    #1 reset = 1'b0;
    #1 check_out("async_reset", 1'b0, 32'h0000_3000, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check_out("reset_held", 1'b0, 32'h0000_3000, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;

    run_vec(mk(0,0,32'h0, 0,32'h0, 1,32'hBADBAD00, 1,32'h0000_3000,32'h0,        0,0), "restart_stale");
    run_vec(mk(0,0,32'h0, 0,32'h0, 0,32'h0,        0,32'h0000_3000,32'h0,        0,0), "restart_wait");
    run_vec(mk(0,0,32'h0, 0,32'h0, 1,32'h2402000A, 0,32'h0000_3000,32'h0,        0,0), "restart_rv");
    run_vec(mk(1,0,32'h0, 0,32'h0, 0,32'h0,        0,32'h0000_3000,32'h2402000A, 1,0), "restart_valid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
